pixel_readout_capture: RTL and testbench

//  Receive-side counterpart of the pixel scan sequencer. Takes one-hot row/col selects plus ADC samples,
//  re-encodes selects to binary addresses, and in CDS mode pairs reset/signal samples into one difference.

---
 rtl/pixel_readout_capture.sv | 187 ++++++++++++++++++
 tb/tb_pixel_readout_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_capture.sv
// Receive side of the pixel scanner: validates and encodes one-hot selects, optionally pairs
// reset/signal samples (CDS) into a clamped difference, and queues tagged results in a FWFT FIFO.
module pixel_readout_capture #(
    parameter int PIXEL_NUM_ROW       = 7,
    parameter int PIXEL_NUM_COL       = 16,
    parameter int ADC_BITS            = 10,
    parameter int FIFO_DEPTH          = 8,
    parameter int PIXEL_ADDR_BITS_ROW = $clog2(PIXEL_NUM_ROW),
    parameter int PIXEL_ADDR_BITS_COL = $clog2(PIXEL_NUM_COL)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic                               correlated_double_sampling,
    input  logic [PIXEL_NUM_ROW-1:0]           row_sel,
    input  logic [PIXEL_NUM_COL-1:0]           col_sel,
    input  logic [ADC_BITS-1:0]                adc_data,
    input  logic                               adc_valid,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ADC_BITS-1:0]                out_data,
    output logic [PIXEL_ADDR_BITS_ROW-1:0]     out_row,
    output logic [PIXEL_ADDR_BITS_COL-1:0]     out_col,
    output logic                               out_frame_end,
    output logic                               onehot_err,
    output logic                               cds_err,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level
);

    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int FILL_BITS = $clog2(FIFO_DEPTH + 1);
    localparam logic [PIXEL_ADDR_BITS_ROW-1:0] LAST_ROW = PIXEL_ADDR_BITS_ROW'(PIXEL_NUM_ROW - 1);
    localparam logic [PIXEL_ADDR_BITS_COL-1:0] LAST_COL = PIXEL_ADDR_BITS_COL'(PIXEL_NUM_COL - 1);

    typedef enum logic {
        IDLE,
        HAVE_RESET
    } state_t;

    typedef struct packed {
        logic [PIXEL_ADDR_BITS_ROW-1:0] row;
        logic [PIXEL_ADDR_BITS_COL-1:0] col;
        logic [ADC_BITS-1:0]            data;
        logic                           frame_end;
    } entry_t;

    state_t                         state_q, state_d;
    logic [ADC_BITS-1:0]            held_data_q, held_data_d;
    logic [PIXEL_ADDR_BITS_ROW-1:0] held_row_q, held_row_d;
    logic [PIXEL_ADDR_BITS_COL-1:0] held_col_q, held_col_d;

    logic [PIXEL_ADDR_BITS_ROW-1:0] row_addr;
    logic [PIXEL_ADDR_BITS_COL-1:0] col_addr;
    logic                           row_onehot, col_onehot;
    logic                           sample, accept;
    logic                           produce;
    entry_t                         entry;
    logic                           onehot_err_d, cds_err_d;

    entry_t                         mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]            wr_ptr_q, rd_ptr_q;
    logic [FILL_BITS-1:0]           count_q;
    logic                           full, push, pop;
    entry_t                         head;

    // x & (x-1) clears the lowest set bit, so a nonzero result means two or more bits set.
    assign row_onehot = (row_sel != '0) && ((row_sel & (row_sel - PIXEL_NUM_ROW'(1))) == '0);
    assign col_onehot = (col_sel != '0) && ((col_sel & (col_sel - PIXEL_NUM_COL'(1))) == '0);

    always_comb begin
        row_addr = '0;
        for (int i = 0; i < PIXEL_NUM_ROW; i++)
            if (row_sel[i]) row_addr = row_addr | PIXEL_ADDR_BITS_ROW'(i);
    end

    always_comb begin
        col_addr = '0;
        for (int i = 0; i < PIXEL_NUM_COL; i++)
            if (col_sel[i]) col_addr = col_addr | PIXEL_ADDR_BITS_COL'(i);
    end

    assign sample = enable && adc_valid;
    assign accept = sample && row_onehot && col_onehot;

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d          = state_q;
        held_data_d      = held_data_q;
        held_row_d       = held_row_q;
        held_col_d       = held_col_q;
        produce          = 1'b0;
        entry.row        = row_addr;
        entry.col        = col_addr;
        entry.data       = adc_data;
        entry.frame_end  = (row_addr == LAST_ROW) && (col_addr == LAST_COL);
        onehot_err_d     = sample && !(row_onehot && col_onehot);
        cds_err_d        = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else if (!correlated_double_sampling) begin
            // Leaving CDS silently drops any held reset level.
            state_d = IDLE;
            produce = accept;
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                    held_data_d = adc_data;
                    held_row_d  = row_addr;
                    held_col_d  = col_addr;
                    state_d     = HAVE_RESET;
                end
                HAVE_RESET: begin
                    if (held_row_q == row_addr && held_col_q == col_addr) begin
                        produce    = 1'b1;
                        entry.data = (held_data_q >= adc_data) ? held_data_q - adc_data : '0;
                        state_d    = IDLE;
                    end else begin
                        held_data_d = adc_data;
                        held_row_d  = row_addr;
                        held_col_d  = col_addr;
                        cds_err_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            held_data_q <= '0;
            held_row_q  <= '0;
            held_col_q  <= '0;
            onehot_err  <= 1'b0;
            cds_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_data_q <= held_data_d;
            held_row_q  <= held_row_d;
            held_col_q  <= held_col_d;
            onehot_err  <= onehot_err_d;
            cds_err     <= cds_err_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FILL_BITS'(FIFO_DEPTH));
    assign pop       = enable && out_valid && out_ready;
    assign push      = produce && (!full || pop);

    // NOTE: FIFO storage has no reset; out_* are gated by out_valid so stale words never show.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else if (!enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            if (push && !pop)      count_q <= count_q + FILL_BITS'(1);
            else if (pop && !push) count_q <= count_q - FILL_BITS'(1);
            if (produce && full && !pop) overflow <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr_q];
    assign out_data      = out_valid ? head.data      : '0;
    assign out_row       = out_valid ? head.row       : '0;
    assign out_col       = out_valid ? head.col       : '0;
    assign out_frame_end = out_valid ? head.frame_end : 1'b0;
    assign fill_level    = count_q;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Self-checking bench for pixel_readout_capture: directed vector table, hand sequences for
// overflow/flush/reset, and randomized traffic checked against a queue-based reference model.
module tb_pixel_readout_capture;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        correlated_double_sampling = 1'b0;
    logic [6:0]  row_sel = '0;
    logic [15:0] col_sel = '0;
    logic [9:0]  adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [9:0]  out_data;
    logic [2:0]  out_row;
    logic [3:0]  out_col;
    logic        out_frame_end;
    logic        onehot_err;
    logic        cds_err;
    logic        overflow;
    logic [3:0]  fill_level;

    int errors = 0;
    int checks = 0;

    pixel_readout_capture dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .enable                     (enable),
        .correlated_double_sampling (correlated_double_sampling),
        .row_sel                    (row_sel),
        .col_sel                    (col_sel),
        .adc_data                   (adc_data),
        .adc_valid                  (adc_valid),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_data                   (out_data),
        .out_row                    (out_row),
        .out_col                    (out_col),
        .out_frame_end              (out_frame_end),
        .onehot_err                 (onehot_err),
        .cds_err                    (cds_err),
        .overflow                   (overflow),
        .fill_level                 (fill_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: a queue of results plus the CDS pairing memory.
    typedef struct packed {
        logic [2:0] row;
        logic [3:0] col;
        logic [9:0] data;
        logic       fe;
    } ent_t;

    ent_t       mq[$];
    logic       m_held_v = 1'b0;
    logic [9:0] m_hd = '0;
    logic [2:0] m_hr = '0;
    logic [3:0] m_hc = '0;
    logic       m_ovf = 1'b0;
    logic       m_oh = 1'b0;
    logic       m_cds = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_held_v = 1'b0;
        m_ovf    = 1'b0;
        m_oh     = 1'b0;
        m_cds    = 1'b0;
    endtask

    // Apply the behavioural rules to the inputs currently on the pins (pre-edge state).
    task automatic model_edge();
        logic       ok, acc, pop, produce, was_full;
        logic [2:0] r;
        logic [3:0] c;
        logic [9:0] val;
        pop = (mq.size() != 0) && out_ready;
        if (!enable) begin
            model_reset();
            return;
        end
        ok      = ($countones(row_sel) == 1) && ($countones(col_sel) == 1);
        acc     = adc_valid && ok;
        m_oh    = adc_valid && !ok;
        m_cds   = 1'b0;
        produce = 1'b0;
        val     = adc_data;
        r       = acc ? 3'($clog2(row_sel)) : 3'd0;
        c       = acc ? 4'($clog2(col_sel)) : 4'd0;
        if (!correlated_double_sampling) begin
            m_held_v = 1'b0;
            produce  = acc;
        end else if (acc) begin
            if (!m_held_v) begin
                m_held_v = 1'b1;
                m_hd = adc_data; m_hr = r; m_hc = c;
            end else if (m_hr == r && m_hc == c) begin
                produce  = 1'b1;
                val      = (m_hd > adc_data) ? 10'(m_hd - adc_data) : 10'd0;
                m_held_v = 1'b0;
            end else begin
                m_hd = adc_data; m_hr = r; m_hc = c;
                m_cds = 1'b1;
            end
        end
        was_full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (produce) begin
            if (!was_full || pop) mq.push_back('{r, c, val, (r == 3'd6 && c == 4'd15)});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        check({tag, " out_valid"},     32'(out_valid),     32'(mq.size() != 0));
        check({tag, " out_row"},       32'(out_row),       32'(h.row));
        check({tag, " out_col"},       32'(out_col),       32'(h.col));
        check({tag, " out_data"},      32'(out_data),      32'(h.data));
        check({tag, " out_frame_end"}, 32'(out_frame_end), 32'(h.fe));
        check({tag, " fill_level"},    32'(fill_level),    32'(mq.size()));
        check({tag, " overflow"},      32'(overflow),      32'(m_ovf));
        check({tag, " onehot_err"},    32'(onehot_err),    32'(m_oh));
        check({tag, " cds_err"},       32'(cds_err),       32'(m_cds));
    endtask

    task automatic cycle(input string tag, input logic en, input logic cds,
                         input logic [6:0] rs, input logic [15:0] cs,
                         input logic [9:0] d, input logic v, input logic rdy);
        enable = en;
        correlated_double_sampling = cds;
        row_sel = rs; col_sel = cs; adc_data = d; adc_valid = v; out_ready = rdy;
        model_edge();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"},     32'(out_valid),     32'd0);
        check({tag, " out_data"},      32'(out_data),      32'd0);
        check({tag, " out_row"},       32'(out_row),       32'd0);
        check({tag, " out_col"},       32'(out_col),       32'd0);
        check({tag, " out_frame_end"}, 32'(out_frame_end), 32'd0);
        check({tag, " onehot_err"},    32'(onehot_err),    32'd0);
        check({tag, " cds_err"},       32'(cds_err),       32'd0);
        check({tag, " overflow"},      32'(overflow),      32'd0);
        check({tag, " fill_level"},    32'(fill_level),    32'd0);
    endtask

    typedef struct packed {
        logic        en, cds;
        logic [6:0]  rs;
        logic [15:0] cs;
        logic [9:0]  d;
        logic        v, rdy;
        logic        e_valid;
        logic [2:0]  e_row;
        logic [3:0]  e_col;
        logic [9:0]  e_data;
        logic        e_fe;
        logic [3:0]  e_fill;
        logic        e_oh, e_cds;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Directed vectors; each row's expectations describe outputs after that row's edge.
        tbl[0]  = '{1'b1, 1'b0, 7'b0000100, 16'h0020, 10'h155, 1'b1, 1'b0, 1'b1, 3'd2, 4'd5,  10'h155, 1'b0, 4'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 7'b0000000, 16'h0000, 10'd0,   1'b0, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 7'b1000000, 16'h8000, 10'd800, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 7'b1000000, 16'h8000, 10'd300, 1'b1, 1'b0, 1'b1, 3'd6, 4'd15, 10'd500, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 7'b1000000, 16'h8000, 10'd300, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 7'b1000000, 16'h8000, 10'd800, 1'b1, 1'b0, 1'b1, 3'd6, 4'd15, 10'd0,   1'b1, 4'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 7'b0000000, 16'h0000, 10'd0,   1'b0, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 7'b0000010, 16'h0002, 10'd90,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 7'b0000010, 16'h0004, 10'd90,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 7'b0000010, 16'h0004, 10'd50,  1'b1, 1'b0, 1'b1, 3'd1, 4'd2,  10'd40,  1'b0, 4'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 7'b0000000, 16'h0000, 10'd0,   1'b0, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 7'b0000010, 16'h0000, 10'd1,   1'b1, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 7'b0000010, 16'h0003, 10'd1,   1'b1, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 7'b0000000, 16'h0000, 10'd0,   1'b0, 1'b1, 1'b0, 3'd0, 4'd0,  10'd0,   1'b0, 4'd0, 1'b0, 1'b0};

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < 14; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].en, tbl[i].cds, tbl[i].rs, tbl[i].cs,
                  tbl[i].d, tbl[i].v, tbl[i].rdy);
            check($sformatf("vec%0d valid", i), 32'(out_valid),     32'(tbl[i].e_valid));
            check($sformatf("vec%0d row", i),   32'(out_row),       32'(tbl[i].e_row));
            check($sformatf("vec%0d col", i),   32'(out_col),       32'(tbl[i].e_col));
            check($sformatf("vec%0d data", i),  32'(out_data),      32'(tbl[i].e_data));
            check($sformatf("vec%0d fe", i),    32'(out_frame_end), 32'(tbl[i].e_fe));
            check($sformatf("vec%0d fill", i),  32'(fill_level),    32'(tbl[i].e_fill));
            check($sformatf("vec%0d oh", i),    32'(onehot_err),    32'(tbl[i].e_oh));
            check($sformatf("vec%0d cds", i),   32'(cds_err),       32'(tbl[i].e_cds));
        end

        // Overflow: nine SS samples with the consumer stalled.
        for (int i = 0; i < 9; i++)
            cycle($sformatf("ovf%0d", i), 1'b1, 1'b0, 7'(1 << (i % 7)), 16'(1 << i),
                  10'(i + 16), 1'b1, 1'b0);
        check("ovf fill",     32'(fill_level), 32'd8);
        check("ovf sticky",   32'(overflow),   32'd1);
        check("ovf head row", 32'(out_row),    32'd0);
        check("ovf head col", 32'(out_col),    32'd0);
        check("ovf head data",32'(out_data),   32'd16);
        cycle("ovf_stall", 1'b1, 1'b0, 7'b0, 16'b0, 10'd0, 1'b0, 1'b0);
        check("ovf stable data", 32'(out_data), 32'd16);
        cycle("full_pushpop", 1'b1, 1'b0, 7'b0000100, 16'h0200, 10'd99, 1'b1, 1'b1);
        check("pushpop fill",  32'(fill_level), 32'd8);
        check("pushpop head",  32'(out_data),   32'd17);

        // Flush: enable low clears FIFO and sticky overflow.
        cycle("flush8", 1'b0, 1'b0, 7'b0000001, 16'h0001, 10'd5, 1'b1, 1'b0);
        check("flush8 fill", 32'(fill_level), 32'd0);
        check("flush8 ovf",  32'(overflow),   32'd0);
        for (int i = 0; i < 3; i++)
            cycle($sformatf("fill3_%0d", i), 1'b1, 1'b0, 7'b0001000, 16'(1 << i),
                  10'(i + 200), 1'b1, 1'b0);
        check("fill3 level", 32'(fill_level), 32'd3);
        cycle("flush3", 1'b0, 1'b1, 7'b0, 16'b0, 10'd0, 1'b0, 1'b0);
        check("flush3 fill", 32'(fill_level), 32'd0);

        // Asynchronous reset while a reset level is held.
        cycle("pre_rst_ss",  1'b1, 1'b0, 7'b0000001, 16'h0001, 10'd33, 1'b1, 1'b0);
        cycle("pre_rst_cds", 1'b1, 1'b1, 7'b0001000, 16'h0010, 10'd700, 1'b1, 1'b0);
        adc_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle("post_rst_a", 1'b1, 1'b1, 7'b0000100, 16'h0008, 10'd100, 1'b1, 1'b0);
        check("post_rst_a fill", 32'(fill_level), 32'd0);
        cycle("post_rst_b", 1'b1, 1'b1, 7'b0000100, 16'h0008, 10'd40, 1'b1, 1'b0);
        check("post_rst_b data", 32'(out_data), 32'd60);
        check("post_rst_b fill", 32'(fill_level), 32'd1);

        // Randomized traffic against the model.
        begin
            logic        en, cds, v, rdy;
            logic [6:0]  rs;
            logic [15:0] cs;
            logic [9:0]  d;
            cds = 1'b0;
            for (int n = 0; n < 600; n++) begin
                en  = ($urandom_range(0, 39) != 0);
                if ($urandom_range(0, 19) == 0) cds = ~cds;
                v   = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 1) == 1);
                rs  = 7'(1 << ($urandom_range(0, 1) ? 6 : $urandom_range(0, 6)));
                cs  = 16'(1 << ($urandom_range(0, 1) ? 15 : $urandom_range(0, 15)));
                if ($urandom_range(0, 15) == 0) rs = 7'($urandom);
                if ($urandom_range(0, 15) == 0) cs = 16'($urandom);
                d   = 10'($urandom);
                cycle("rand", en, cds, rs, cs, d, v, rdy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
